gen_big_field_table: RTL

Frame-header inserter that is the transmit-side counterpart of the big-field parser. On each incoming AXI-stream frame it first emits a FIELD_LEN-word header taken from a parallel value array, then forwards the upstream frame payload unchanged. Its output is exactly what the big-field parser strips and restores. It sits upstream of that parser, or on the TX side of any link that the parser terminates.

---
 rtl/gen_big_field_table_if.sv | 28 ++
 rtl/gen_big_field_table.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/gen_big_field_table_if.sv
// -----------------------------------------------------------------------------
// axi_stream_inf : AXI-stream bundle shared by the header inserter and its
// neighbours. The clock is not part of the bundle; every user runs on the
// single design clock.
//
//   tvalid/tready : handshake
//   tdata         : DSIZE-bit word
//   tkeep         : byte enables, one per started byte of tdata
//   tuser         : single side-band bit
//   tlast         : last word of a frame
//
// Modports: master drives the payload and samples tready, slaver the reverse.
// -----------------------------------------------------------------------------
interface axi_stream_inf #(
    parameter int DSIZE = 8
) ();
    localparam int KSIZE = (DSIZE + 7) / 8;

    logic             tvalid;
    logic             tready;
    logic [DSIZE-1:0] tdata;
    logic [KSIZE-1:0] tkeep;
    logic             tuser;
    logic             tlast;

    modport master (output tvalid, tdata, tkeep, tuser, tlast, input tready);
    modport slaver (input tvalid, tdata, tkeep, tuser, tlast, output tready);
endinterface

// File: rtl/gen_big_field_table.sv
// -----------------------------------------------------------------------------
// gen_big_field_table : transmit-side frame-header inserter.
//
// For every upstream AXI-stream frame the block optionally emits FIELD_LEN
// header words (taken from a snapshot of `value`, value[0] first) and then
// forwards the frame payload unchanged, with zero added latency once the body
// is flowing.
//
// Ports
//   clock      : single clock for both stream interfaces
//   rst_n      : asynchronous active-low reset
//   enable     : insert a header on this frame; sampled at frame start only
//   value      : header words, snapshotted at frame start
//   busy       : high from frame start until the cycle after the body tlast
//   cm_tb_s    : payload frames in  (slaver)
//   cm_tb_m    : header + payload frames out (master)
//   frame_cnt  : body tlast handshakes seen       (GEN_BIG_FIELD_STAT_EN only)
//   hdr_cnt    : frames that carried a header     (GEN_BIG_FIELD_STAT_EN only)
//
// Build option: define GEN_BIG_FIELD_STAT_EN to add the two 16-bit wrapping
// statistics counters. Without it the ports and logic do not exist.
// -----------------------------------------------------------------------------
module gen_big_field_table #(
    parameter int DSIZE      = 8,
    parameter int FIELD_LEN  = 16 * 8,
    parameter     FIELD_NAME = "Big Filed"
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [DSIZE-1:0] value [0:FIELD_LEN-1],
    output logic             busy,
`ifdef GEN_BIG_FIELD_STAT_EN
    output logic [15:0]      frame_cnt,
    output logic [15:0]      hdr_cnt,
`endif
    axi_stream_inf.slaver    cm_tb_s,
    axi_stream_inf.master    cm_tb_m
);
    localparam int KSIZE = (DSIZE + 7) / 8;
    // A 1-word header still needs a 1-bit counter.
    localparam int            CW       = (FIELD_LEN > 1) ? $clog2(FIELD_LEN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(FIELD_LEN - 1);

    typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             load_shadow;
    logic [DSIZE-1:0] shadow_q [0:FIELD_LEN-1];

    logic             m_tvalid;
    logic [DSIZE-1:0] m_tdata;
    logic [KSIZE-1:0] m_tkeep;
    logic             m_tuser;
    logic             m_tlast;
    logic             s_tready;

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave a value held (no latches).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_shadow = 1'b0;
        m_tvalid    = 1'b0;
        m_tdata     = '0;
        m_tkeep     = '0;
        m_tuser     = 1'b0;
        m_tlast     = 1'b0;
        s_tready    = 1'b0;

        case (state_q)
            IDLE: begin
                // Frame start: the upstream word is held (tready=0) while we
                // decide between header insertion and plain pass-through.
                if (cm_tb_s.tvalid) begin
                    if (enable) begin
                        load_shadow = 1'b1;
                        cnt_d       = '0;
                        state_d     = HEAD;
                    end else begin
                        state_d = BODY;
                    end
                end
            end
            HEAD: begin
                m_tvalid = 1'b1;
                m_tdata  = shadow_q[cnt_q];
                m_tkeep  = '1;
                if (cm_tb_m.tready) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = BODY;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            BODY: begin
                m_tvalid = cm_tb_s.tvalid;
                m_tdata  = cm_tb_s.tdata;
                m_tkeep  = cm_tb_s.tkeep;
                m_tuser  = cm_tb_s.tuser;
                m_tlast  = cm_tb_s.tlast;
                s_tready = cm_tb_m.tready;
                if (cm_tb_s.tvalid && cm_tb_m.tready && cm_tb_s.tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Rises with the exit from IDLE, falls one cycle after the return.
        busy_d = (state_q != IDLE) || (state_d != IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop sees
    // the pre-edge value of every other flop.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // NOTE: the shadow array carries no reset; it is always reloaded before
    // HEAD reads it, so a reset would only cost routing.
    always_ff @(posedge clock) begin
        if (load_shadow) begin
            shadow_q <= value;
        end
    end

`ifdef GEN_BIG_FIELD_STAT_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] hdr_cnt_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            hdr_cnt_q   <= '0;
        end else begin
            if (state_q == BODY && cm_tb_s.tvalid && cm_tb_m.tready && cm_tb_s.tlast) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (load_shadow) begin
                hdr_cnt_q <= hdr_cnt_q + 16'd1;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign hdr_cnt   = hdr_cnt_q;
`endif

    // The header index can never leave the shadow array.
    always_ff @(posedge clock) begin
        if (rst_n && state_q == HEAD) begin
            assert (int'(cnt_q) < FIELD_LEN)
                else $error("%s: header index %0d out of range", FIELD_NAME, cnt_q);
        end
    end

    assign busy           = busy_q;
    assign cm_tb_m.tvalid = m_tvalid;
    assign cm_tb_m.tdata  = m_tdata;
    assign cm_tb_m.tkeep  = m_tkeep;
    assign cm_tb_m.tuser  = m_tuser;
    assign cm_tb_m.tlast  = m_tlast;
    assign cm_tb_s.tready = s_tready;
endmodule
